// File: rtl/ring_digit_scanner.sv
// Scans four double-buffered BCD digits onto a common-cathode 7-segment display,
// timed by a one-hot ring phase. Optional macro: LEADING_ZERO_BLANK_EN.
module ring_digit_scanner #(
   parameter int FRAME_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         phase,
   input  logic               load,
   input  logic [15:0]        digits_in,
   output logic               load_ready,
   output logic [3:0]         an,
   output logic [6:0]         seg,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               phase_err
);

   typedef enum logic [1:0] {SYNC, SCAN, FAULT} state_t;

   state_t        state;
   logic [3:0]    prev_phase;
   logic [15:0]   shadow;
   logic [15:0]   active;
   logic          pending;

   logic          onehot;
   logic          step_ok;
   logic          start;
   logic          wrap;
   logic          next_scan;
   logic          boundary;
   logic          fault;
   logic          frame_tick;
   logic          transfer;
   logic [15:0]   shown;
   logic [3:0]    digit;
   logic [6:0]    seg_next;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b0111111;
         4'd1:    decode = 7'b0000110;
         4'd2:    decode = 7'b1011011;
         4'd3:    decode = 7'b1001111;
         4'd4:    decode = 7'b1100110;
         4'd5:    decode = 7'b1101101;
         4'd6:    decode = 7'b1111101;
         4'd7:    decode = 7'b0000111;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1101111;
         default: decode = 7'b1000000;
      endcase
   endfunction

   assign load_ready = ~pending;
   assign onehot     = (phase == 4'b0001) || (phase == 4'b0010) ||
                       (phase == 4'b0100) || (phase == 4'b1000);
   assign step_ok    = onehot && ((phase == prev_phase) ||
                                  (phase == {prev_phase[2:0], prev_phase[3]}));
   assign start      = (phase == 4'b0001);
   assign wrap       = start && (prev_phase == 4'b1000);

   always_comb begin
      next_scan  = 1'b0;
      boundary   = 1'b0;
      fault      = 1'b0;
      frame_tick = 1'b0;
      case (state)
         SCAN: begin
            if (step_ok) begin
               next_scan  = 1'b1;
               boundary   = wrap;
               frame_tick = wrap;
            end else begin
               fault = 1'b1;
            end
         end
         default: begin
            if (start) begin
               next_scan = 1'b1;
               boundary  = 1'b1;
            end
         end
      endcase
   end

   // Bypass the shadow on a transfer so the new set shows from the boundary phase.
   assign transfer = boundary && pending;
   assign shown    = transfer ? shadow : active;

   always_comb begin
      digit = shown[3:0];
      case (phase)
         4'b0010: digit = shown[7:4];
         4'b0100: digit = shown[11:8];
         4'b1000: digit = shown[15:12];
         default: digit = shown[3:0];
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lz_blank;
   assign lz_blank = (phase[3] && (shown[15:12] == 4'd0)) ||
                     (phase[2] && (shown[15:8]  == 8'd0)) ||
                     (phase[1] && (shown[15:4]  == 12'd0));
   assign seg_next = lz_blank ? 7'b0000000 : decode(digit);
`else
   assign seg_next = decode(digit);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= SYNC;
         prev_phase <= 4'b0000;
         shadow     <= 16'h0000;
         active     <= 16'h0000;
         pending    <= 1'b0;
         an         <= 4'b1111;
         seg        <= 7'b0000000;
         frame_cnt  <= '0;
         phase_err  <= 1'b0;
      end else begin
         prev_phase <= phase;
         if (transfer) begin
            active  <= shadow;
            pending <= 1'b0;
         end else if (load && !pending) begin
            shadow  <= digits_in;
            pending <= 1'b1;
         end
         if (fault)
            phase_err <= 1'b1;
         if (frame_tick)
            frame_cnt <= frame_cnt + FRAME_W'(1);
         if (next_scan) begin
            state <= SCAN;
            an    <= ~phase;
            seg   <= seg_next;
         end else begin
            if (fault)
               state <= FAULT;
            an  <= 4'b1111;
            seg <= 7'b0000000;
         end
      end
   end

endmodule

// File: tb/tb_ring_digit_scanner.sv
// Self-checking bench for ring_digit_scanner: vector table plus hand-written corner sequences,
// expected outputs queued at drive time and popped one clock later.
module tb_ring_digit_scanner;

   logic        clk;
   logic        rst;
   logic [3:0]  phase;
   logic        load;
   logic [15:0] digits_in;
   logic        load_ready;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [7:0]  frame_cnt;
   logic        phase_err;

   int total;
   int bad;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       rdy;
      logic       err;
      string      name;
   } exp_t;

   typedef struct {
      logic [3:0]  ph;
      logic        ld;
      logic [15:0] din;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        rdy;
      logic        err;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[13];

   logic [6:0] segTab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   ring_digit_scanner #(.FRAME_W(8)) dut (
      .clk(clk), .rst(rst), .phase(phase), .load(load), .digits_in(digits_in),
      .load_ready(load_ready), .an(an), .seg(seg), .frame_cnt(frame_cnt),
      .phase_err(phase_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected segment pattern for whichever digit a one-hot phase selects.
   function automatic logic [6:0] segOf(input logic [15:0] d, input logic [3:0] ph);
      logic [3:0] nib;
      logic       blank;
      int         idx;
      idx = (ph == 4'b0010) ? 1 : (ph == 4'b0100) ? 2 : (ph == 4'b1000) ? 3 : 0;
      nib = d[idx*4 +: 4];
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx == 3) blank = (d[15:12] == 4'd0);
      if (idx == 2) blank = (d[15:8] == 8'd0);
      if (idx == 1) blank = (d[15:4] == 12'd0);
`endif
      segOf = blank ? 7'b0000000 : segTab[nib];
   endfunction

   task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard: empty queue, got an=%b seg=%b", an, seg);
      end else begin
         e = sb.pop_front();
         checkVal({e.name, ".an"},  16'(an), 16'(e.an));
         checkVal({e.name, ".seg"}, 16'(seg), 16'(e.seg));
         checkVal({e.name, ".rdy"}, 16'(load_ready), 16'(e.rdy));
         checkVal({e.name, ".err"}, 16'(phase_err), 16'(e.err));
      end
   endtask

   task automatic applyStimulus(input logic [3:0] ph, input logic ld, input logic [15:0] din,
                                input logic [3:0] ean, input logic [6:0] eseg,
                                input logic erdy, input logic eerr, input string name);
      exp_t e;
      @(negedge clk);
      phase     = ph;
      load      = ld;
      digits_in = din;
      e.an = ean; e.seg = eseg; e.rdy = erdy; e.err = eerr; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic scanStep(input logic [3:0] ph, input logic [15:0] d, input logic erdy,
                           input logic eerr, input string name);
      applyStimulus(ph, 1'b0, 16'h0, ~ph, segOf(d, ph), erdy, eerr, name);
   endtask

   task automatic driveOnly(input logic [3:0] ph);
      @(negedge clk);
      phase = ph;
      load  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      phase = 4'b0000;
      load = 1'b0;
      digits_in = 16'h0;
      #1;
      checkVal("rst.an", 16'(an), 16'hF);
      checkVal("rst.seg", 16'(seg), 16'h0);
      checkVal("rst.frame", 16'(frame_cnt), 16'h0);
      checkVal("rst.err", 16'(phase_err), 16'h0);
      checkVal("rst.rdy", 16'(load_ready), 16'h1);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b0;
      phase = 4'b0000;
      load = 1'b0;
      digits_in = 16'h0;

      for (int i = 0; i < 13; i++) begin
         vecs[i].ph  = 4'b0001 << (i % 4);
         vecs[i].ld  = 1'b0;
         vecs[i].din = 16'h0;
         vecs[i].an  = ~vecs[i].ph;
         vecs[i].seg = segOf(16'h0000, vecs[i].ph);
         vecs[i].rdy = 1'b1;
         vecs[i].err = 1'b0;
      end

      // Basic scan of an all-zero active set.
      doReset();
      for (int i = 0; i < 13; i++)
         applyStimulus(vecs[i].ph, vecs[i].ld, vecs[i].din, vecs[i].an, vecs[i].seg,
                       vecs[i].rdy, vecs[i].err, $sformatf("scan%0d", i));
      checkVal("scan.frame", 16'(frame_cnt), 16'd3);

      // Non-start phase while syncing is ignored without error.
      doReset();
      for (int i = 0; i < 5; i++)
         applyStimulus(4'b0100, 1'b0, 16'h0, 4'b1111, 7'h00, 1'b1, 1'b0, "hold");
      scanStep(4'b0001, 16'h0000, 1'b1, 1'b0, "syncStart");
      checkVal("sync.frame", 16'(frame_cnt), 16'd0);

      // Load mid-frame, second load while pending ignored, transfer at the wrap.
      applyStimulus(4'b0010, 1'b1, 16'h1234, 4'b1101, segOf(16'h0, 4'b0010), 1'b0, 1'b0, "load1");
      applyStimulus(4'b0100, 1'b1, 16'h9999, 4'b1011, segOf(16'h0, 4'b0100), 1'b0, 1'b0, "load2");
      applyStimulus(4'b1000, 1'b0, 16'h0, 4'b0111, segOf(16'h0, 4'b1000), 1'b0, 1'b0, "pend");
      scanStep(4'b0001, 16'h1234, 1'b1, 1'b0, "xfer0");
      scanStep(4'b0010, 16'h1234, 1'b1, 1'b0, "xfer1");
      scanStep(4'b0100, 16'h1234, 1'b1, 1'b0, "xfer2");
      scanStep(4'b1000, 16'h1234, 1'b1, 1'b0, "xfer3");
      checkVal("xfer.frame", 16'(frame_cnt), 16'd1);

      // Illegal value, then illegal step, then restart from the first phase.
      scanStep(4'b0001, 16'h1234, 1'b1, 1'b0, "preFault");
      applyStimulus(4'b0011, 1'b0, 16'h0, 4'b1111, 7'h00, 1'b1, 1'b1, "fault");
      applyStimulus(4'b0010, 1'b0, 16'h0, 4'b1111, 7'h00, 1'b1, 1'b1, "faultHold");
      scanStep(4'b0001, 16'h1234, 1'b1, 1'b1, "rescan");
      checkVal("fault.frame", 16'(frame_cnt), 16'd2);

      // Load accepted on a boundary waits for the next boundary.
      scanStep(4'b0010, 16'h1234, 1'b1, 1'b1, "b1");
      scanStep(4'b0100, 16'h1234, 1'b1, 1'b1, "b2");
      scanStep(4'b1000, 16'h1234, 1'b1, 1'b1, "b3");
      applyStimulus(4'b0001, 1'b1, 16'h5678, 4'b1110, segOf(16'h1234, 4'b0001), 1'b0, 1'b1, "bLoad");
      scanStep(4'b0010, 16'h1234, 1'b0, 1'b1, "bWait1");
      scanStep(4'b0100, 16'h1234, 1'b0, 1'b1, "bWait2");
      scanStep(4'b1000, 16'h1234, 1'b0, 1'b1, "bWait3");
      scanStep(4'b0001, 16'h5678, 1'b1, 1'b1, "bXfer0");
      scanStep(4'b0010, 16'h5678, 1'b1, 1'b1, "bXfer1");

      // Asynchronous reset mid-operation discards a pending load.
      applyStimulus(4'b0100, 1'b1, 16'h1111, 4'b1011, segOf(16'h5678, 4'b0100), 1'b0, 1'b1, "preRst");
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkVal("midRst.an", 16'(an), 16'hF);
      checkVal("midRst.rdy", 16'(load_ready), 16'h1);
      checkVal("midRst.err", 16'(phase_err), 16'h0);
      checkVal("midRst.frame", 16'(frame_cnt), 16'h0);
      phase = 4'b0000;
      load = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      scanStep(4'b0001, 16'h0000, 1'b1, 1'b0, "postRst");

      // Frame counter wrap.
      for (int f = 0; f < 255; f++) begin
         driveOnly(4'b0010);
         driveOnly(4'b0100);
         driveOnly(4'b1000);
         driveOnly(4'b0001);
      end
      checkVal("frame255", 16'(frame_cnt), 16'd255);
      driveOnly(4'b0010);
      driveOnly(4'b0100);
      driveOnly(4'b1000);
      driveOnly(4'b0001);
      checkVal("frameWrap", 16'(frame_cnt), 16'd0);

      // Leading-zero candidate digits loaded while syncing.
      doReset();
      applyStimulus(4'b0000, 1'b1, 16'h0050, 4'b1111, 7'h00, 1'b0, 1'b0, "lzLoad");
      scanStep(4'b0001, 16'h0050, 1'b1, 1'b0, "lz0");
      scanStep(4'b0010, 16'h0050, 1'b1, 1'b0, "lz1");
      scanStep(4'b0100, 16'h0050, 1'b1, 1'b0, "lz2");
      scanStep(4'b1000, 16'h0050, 1'b1, 1'b0, "lz3");

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard: %0d leftover entries, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ring_digit_scanner.md
Name: ring_digit_scanner

Overview:
- Downstream consumer of the 4-bit one-hot ring counter.
- Uses the ring phase to time-multiplex four BCD digits onto a common-cathode 7-segment display.
- Double-buffers digit updates so a new value never tears mid-frame.
- Checks the phase sequence for legality and blanks the display on a fault.

Parameters:
- FRAME_W, 8, width of the frame counter; wraps modulo 2^FRAME_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- phase  input  4  one-hot phase from the ring counter; phase[i]=1 selects digit i.
- load  input  1  request to load a new digit set.
- digits_in  input  16  four BCD digits; [3:0]=digit0 … [15:12]=digit3.
- load_ready  output  1  high when the shadow buffer is free; load is accepted only when load & load_ready.
- an  output  4  digit enables, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- frame_cnt  output  FRAME_W  count of completed scan frames.
- phase_err  output  1  sticky illegal-phase flag.

Behaviour:
- Reset values (rst=0, asynchronous):
  - an=4'b1111, seg=7'b0000000, frame_cnt=0, phase_err=0, load_ready=1.
  - Shadow and active digit registers = 0; state = SYNC.
- Legal phase: exactly one bit set. Legal step: phase equals the previous phase (hold) or rotate-left of it (0001→0010→0100→1000→0001).
- FSM states SYNC, SCAN, FAULT; registered, one transition per clock.
  - SYNC: outputs blanked. Phase==0001 → SCAN and triggers a frame-boundary transfer. Any other phase value is ignored; no error is raised.
  - SCAN: any illegal value or illegal step → FAULT and phase_err<=1. Otherwise the display is driven.
  - FAULT: outputs blanked. Phase==0001 → SCAN with a transfer; otherwise stay. phase_err stays 1 until reset.
- Display latency: an/seg are registered, one cycle after phase is sampled.
  - For phase[i]=1 in SCAN: an = ~phase, seg = decode(active digit i).
  - Blanked means an=1111, seg=0000000.
- Decode:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110.
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - 10–15 = 1000000 (dash).
- Frame counting: frame_cnt increments on each SCAN step 1000→0001 and wraps 2^FRAME_W-1 → 0. It is not incremented by a SYNC/FAULT→SCAN entry, and it holds in SYNC and FAULT.
- Load handshake:
  - load & load_ready: digits_in → shadow, pending<=1, so load_ready=0 from the next cycle.
  - load while load_ready=0 is ignored; the shadow contents are not altered.
- Transfer: at a frame boundary (SCAN wrap 1000→0001, or entry to SCAN) with pending=1, shadow → active and pending<=0.
  - The new digits are displayed from the 0001 phase of that frame; a/seg reflect them one cycle later.
- Simultaneous events:
  - A load accepted in the same cycle as a boundary is not transferred in that cycle; it waits for the next boundary.
  - A boundary with pending=0 leaves the active digits unchanged.
- Reset mid-operation: all state returns to reset values immediately, and any pending load is discarded.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: while the digit is shown, seg=0000000 (an still asserted) for:
  - digit 3 if it is 0;
  - digit 2 if it and digit 3 are 0;
  - digit 1 if it, digit 2 and digit 3 are 0.
  Digit 0 is never blanked. Dash digits count as non-zero.
- Undefined: all digits are always decoded; no extra logic is present.

Test Plan:
- Reset, then drive phase 0001,0010,0100,1000 repeatedly with active=0 → an follows ~phase one cycle late, seg=0111111; frame_cnt increments once per 1000→0001.
- From reset, hold phase=0100 for 5 cycles, then 0001 → display blanked and phase_err=0 during the 0100 hold; scanning starts from 0001.
- Pulse load with digits_in=16'h1234 mid-frame → load_ready=0 the next cycle. At the following 0001, digit0 seg=1100110 (4) and digit3 seg=0000110 (1). load_ready=1 after the transfer.
- Second load while pending (16'h9999) → ignored; 16'h1234 is displayed.
- In SCAN inject phase 0011, then 0010, then 0001 → FAULT with blanked outputs, phase_err=1; rescans from 0001 with phase_err still 1.
- Run 256 frames with FRAME_W=8 → frame_cnt wraps 255→0. With LEADING_ZERO_BLANK_EN and digits 16'h0050, digit3 and digit2 blank, digit1=1101101 (5), digit0=0111111 (0).
